// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults and types
// for the systolic skew feeder.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIM        = 4;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                      clr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: DEPTH-stage register chain
// carrying one {clr,data} beat per cycle.
module skew_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] r_q;

  // shift the beat one stage per cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_q[k] <= r_q[k-1];
      end
    end
  end

  assign q_o = r_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews operand slices
// onto the PE edge with clear and drain.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_last_i,
  input  logic [DIM*DATA_WIDTH-1:0] in_data_i,
  output logic [DIM*DATA_WIDTH-1:0] lane_data_o,
  output logic [DIM-1:0]            lane_clr_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CW = $clog2(DIM + 1);
  localparam int BW = DATA_WIDTH + 1;

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_done;
  logic          w_done_d;
  logic          w_ready;
  logic          w_inj_clr;
  logic          w_inj_dat;

  // state, drain counter and done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
    end
  end

  // next state, ready and beat select
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
    w_ready   = 1'b0;
    w_inj_clr = 1'b0;
    w_inj_dat = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid_i) w_state_d = CLEAR;
      end
      CLEAR: begin
        w_inj_clr = 1'b1;
        w_state_d = STREAM;
      end
      STREAM: begin
        w_ready = 1'b1;
        if (in_valid_i) begin
          w_inj_dat = 1'b1;
          if (in_last_i) begin
            w_state_d = DRAIN;
            w_cnt_d   = CW'(DIM);
          end
        end
      end
      DRAIN: begin
        w_cnt_d = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_d = IDLE;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic [BW-1:0]         w_in;
    logic [BW-1:0]         w_out;
    logic [DATA_WIDTH-1:0] w_op;

    assign w_op = in_data_i[j*DATA_WIDTH +: DATA_WIDTH]
                & {DATA_WIDTH{w_inj_dat}};
    assign w_in = {w_inj_clr, w_op};

    skew_delay_line #(
      .WIDTH (BW),
      .DEPTH (j + 1)
    ) u_dl (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (w_in),
      .q_o    (w_out)
    );

    assign lane_clr_o[j] = w_out[BW-1];
    assign lane_data_o[j*DATA_WIDTH +: DATA_WIDTH] =
      w_out[DATA_WIDTH-1:0];
  end

  assign in_ready_o = w_ready;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: random vectors checked
// against a per-cycle expected timeline.
module tb_systolic_skew_feeder;

  localparam int DW  = 8;
  localparam int DIM = 4;
  localparam int LW  = DIM * DW;
  localparam int NC  = 2000;
  localparam int NV  = 30;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          in_last_i = 1'b0;
  logic [LW-1:0] in_data_i = '0;
  logic [LW-1:0] lane_data_o;
  logic [DIM-1:0] lane_clr_o;
  logic          busy_o;
  logic          done_o;

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .DIM        (DIM)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .in_data_i   (in_data_i),
    .lane_data_o (lane_data_o),
    .lane_clr_o  (lane_clr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h",
               tag, obs, exp);
    end
  endtask

  bit             pv [NC];
  bit             pl [NC];
  logic [LW-1:0]  pd [NC];
  logic [LW-1:0]  ed [NC];
  logic [DIM-1:0] ec [NC];
  bit             er [NC];
  bit             eb [NC];
  bit             edn[NC];
  int             nend;

  task automatic build_plan();
    int c, r, s, n, acc, gap, bub;
    logic [LW-1:0] sl;
    for (int i = 0; i < NC; i++) begin
      pv[i]  = 1'b0;
      pl[i]  = 1'($urandom);
      pd[i]  = LW'($urandom);
      ed[i]  = '0;
      ec[i]  = '0;
      er[i]  = 1'b0;
      eb[i]  = 1'b0;
      edn[i] = 1'b0;
    end
    c = 1;
    for (int v = 0; v < NV; v++) begin
      r = c;
      pv[r] = 1'b1;
      pv[r+1] = 1'($urandom);
      eb[r+1] = 1'b1;
      for (int j = 0; j < DIM; j++)
        ec[r+2+j][j] = 1'b1;
      if (v == 0) n = 4;
      else if (v <= 2) n = 1;
      else n = int'($urandom_range(1, 6));
      s = r + 2;
      acc = 0;
      bub = 0;
      while (acc < n) begin
        er[s] = 1'b1;
        eb[s] = 1'b1;
        if (v == 0 && acc == 2 && bub < 2) begin
          bub++;
          pv[s] = 1'b0;
        end else if (v >= 3 &&
                     $urandom_range(0, 3) == 0) begin
          pv[s] = 1'b0;
        end else begin
          sl = LW'($urandom);
          if (v == 0 && acc == 0) sl = 32'h04030201;
          if (v == 0 && acc == 1) sl = 32'h08070605;
          if (v == 0 && acc == 2) sl = 32'h007FFF80;
          if (v == 1) sl = 32'hF9FBFDFF;
          pv[s] = 1'b1;
          pd[s] = sl;
          pl[s] = (acc == n - 1);
          acc++;
          for (int j = 0; j < DIM; j++)
            ed[s+1+j][j*DW +: DW] = sl[j*DW +: DW];
        end
        s++;
      end
      for (int d = 1; d <= DIM; d++) begin
        eb[s-1+d] = 1'b1;
        pv[s-1+d] = 1'($urandom);
      end
      edn[s+DIM] = 1'b1;
      gap = (v == 0) ? 0 : int'($urandom_range(0, 3));
      c = s + DIM + gap;
    end
    nend = c + DIM + 4;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 64'(lane_data_o), 64'd0);
    chk({tag, "_clr"}, 64'(lane_clr_o), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    build_plan();
    #3;
    chk_all_zero("rst0");
    @(negedge clk);
    rst_ni = 1'b1;

    for (int c = 0; c < nend; c++) begin
      @(posedge clk);
      #1;
      in_valid_i = pv[c];
      in_last_i  = pl[c];
      in_data_i  = pd[c];
      @(negedge clk);
      chk($sformatf("ready@%0d", c),
          64'(in_ready_o), 64'(er[c]));
      chk($sformatf("busy@%0d", c),
          64'(busy_o), 64'(eb[c]));
      chk($sformatf("done@%0d", c),
          64'(done_o), 64'(edn[c]));
      chk($sformatf("clr@%0d", c),
          64'(lane_clr_o), 64'(ec[c]));
      chk($sformatf("data@%0d", c),
          64'(lane_data_o), 64'(ed[c]));
    end

    @(posedge clk);
    #1;
    in_valid_i = 1'b1;
    in_last_i  = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      in_data_i = LW'($urandom);
    end
    #2;
    chk("pre_rst_ready", 64'(in_ready_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_ni = 1'b1;
    in_valid_i = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk_all_zero("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
